// File: rtl/comparator.sv
// Unsigned WIDTH-bit magnitude comparator with combinational flags and
// one-cycle registered copies for pipelined consumers.
module comparator #(
  parameter int WIDTH = 2
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out,
  output logic             lt,
  output logic             gt,
  output logic             out_q,
  output logic             lt_q,
  output logic             gt_q
);

  logic eq_next;
  logic lt_next;
  logic gt_next;
  logic eq_reg;
  logic lt_reg;
  logic gt_reg;

  // The equality path feeds same-cycle counting logic, so keep it combinational.
  always_comb begin
    eq_next = (A == B);
    lt_next = (A < B);
    gt_next = (A > B);
  end

  assign out = eq_next;
  assign lt  = lt_next;
  assign gt  = gt_next;

  // Reset wins over capture; every non-reset edge samples the current flags.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      eq_reg <= 1'b0;
      lt_reg <= 1'b0;
      gt_reg <= 1'b0;
    end else begin
      eq_reg <= eq_next;
      lt_reg <= lt_next;
      gt_reg <= gt_next;
    end
  end

  assign out_q = eq_reg;
  assign lt_q  = lt_reg;
  assign gt_q  = gt_reg;

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench: WIDTH = 2, 8 and 1 instances against an integer
// arithmetic reference model, with directed and random steps.
module tb_comparator;

  logic       clk;
  logic       reset;
  logic [1:0] a2, b2;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic out2, lt2, gt2, out_q2, lt_q2, gt_q2;
  logic out8, lt8, gt8, out_q8, lt_q8, gt_q8;
  logic out1, lt1, gt1, out_q1, lt_q1, gt_q1;

  int checks = 0;
  int errors = 0;

  comparator #(.WIDTH(2)) u_w2 (
    .CLOCK_50(clk), .reset(reset), .A(a2), .B(b2),
    .out(out2), .lt(lt2), .gt(gt2),
    .out_q(out_q2), .lt_q(lt_q2), .gt_q(gt_q2)
  );

  comparator #(.WIDTH(8)) u_w8 (
    .CLOCK_50(clk), .reset(reset), .A(a8), .B(b8),
    .out(out8), .lt(lt8), .gt(gt8),
    .out_q(out_q8), .lt_q(lt_q8), .gt_q(gt_q8)
  );

  comparator #(.WIDTH(1)) u_w1 (
    .CLOCK_50(clk), .reset(reset), .A(a1), .B(b1),
    .out(out1), .lt(lt1), .gt(gt1),
    .out_q(out_q1), .lt_q(lt_q1), .gt_q(gt_q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: flags {eq, lt, gt} from plain integer comparison.
  function automatic logic [2:0] model(input int a, input int b);
    return {a == b, a < b, a > b};
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Let inputs settle, then check combinational flags and one-hotness.
  task automatic check_comb(input string tag);
    logic [2:0] o2, o8, o1;
    #1;
    o2 = {out2, lt2, gt2};
    o8 = {out8, lt8, gt8};
    o1 = {out1, lt1, gt1};
    check({tag, "_c2"}, o2, model(int'(a2), int'(b2)));
    check({tag, "_c8"}, o8, model(int'(a8), int'(b8)));
    check({tag, "_c1"}, o1, model(int'(a1), int'(b1)));
    check({tag, "_onehot2"}, 3'($countones(o2)), 3'd1);
    $display("step %s A2=%0d B2=%0d A8=%0h B8=%0h A1=%0d B1=%0d flags2=%b flags8=%b flags1=%b",
             tag, a2, b2, a8, b8, a1, b1, o2, o8, o1);
  endtask

  // Advance one edge, checking registered flags against the prediction
  // made from the inputs and reset present before the edge.
  task automatic tick(input string tag);
    logic [2:0] e2, e8, e1;
    e2 = reset ? 3'b000 : model(int'(a2), int'(b2));
    e8 = reset ? 3'b000 : model(int'(a8), int'(b8));
    e1 = reset ? 3'b000 : model(int'(a1), int'(b1));
    @(posedge clk);
    #1;
    check({tag, "_q2"}, {out_q2, lt_q2, gt_q2}, e2);
    check({tag, "_q8"}, {out_q8, lt_q8, gt_q8}, e8);
    check({tag, "_q1"}, {out_q1, lt_q1, gt_q1}, e1);
    $display("edge %s rst=%0d q2=%b q8=%b q1=%b", tag, reset,
             {out_q2, lt_q2, gt_q2}, {out_q8, lt_q8, gt_q8}, {out_q1, lt_q1, gt_q1});
  endtask

  initial begin
    // Reset held for two edges with equal operands.
    reset = 1'b1;
    a2 = 2'd3; b2 = 2'd3; a8 = 8'hA5; b8 = 8'hA5; a1 = 1'b1; b1 = 1'b1;
    check_comb("rst_in");
    tick("rst0");
    tick("rst1");
    check("rst_zero", {out_q2, lt_q2, gt_q2}, 3'b000);
    check_comb("rst_hold");
    reset = 1'b0;
    tick("rst_rel");
    check("rel_eq", {out_q2, lt_q2, gt_q2}, 3'b100);

    // Exhaustive WIDTH = 2 sweep.
    for (int i = 0; i < 16; i++) begin
      a2 = 2'(i / 4);
      b2 = 2'(i % 4);
      check_comb($sformatf("sweep%0d", i));
    end

    // Registered latency.
    a2 = 2'd0; b2 = 2'd0;
    tick("lat_n");
    check("lat_eq", {out_q2, lt_q2, gt_q2}, 3'b100);
    a2 = 2'd3;
    tick("lat_n1");
    check("lat_gt", {out_q2, lt_q2, gt_q2}, 3'b001);

    // Mid-stream reset while alternating 1/2 and 2/1.
    for (int i = 0; i < 8; i++) begin
      a2 = (i % 2 == 0) ? 2'd1 : 2'd2;
      b2 = (i % 2 == 0) ? 2'd2 : 2'd1;
      reset = (i == 4);
      check_comb($sformatf("mid%0d", i));
      tick($sformatf("mid%0d", i));
    end
    reset = 1'b0;

    // WIDTH = 8 directed boundaries.
    a8 = 8'hFF; b8 = 8'h00; check_comb("w8_gt");
    check("w8_gt_flag", {out8, lt8, gt8}, 3'b001);
    a8 = 8'h7F; b8 = 8'h80; check_comb("w8_lt");
    check("w8_lt_flag", {out8, lt8, gt8}, 3'b010);
    a8 = 8'hA5; b8 = 8'hA5; check_comb("w8_eq");
    a8 = 8'h00; b8 = 8'h00; check_comb("w8_zero");
    a8 = 8'h00; b8 = 8'hFF; check_comb("w8_lt_max");
    tick("w8_reg");

    // WIDTH = 1: all pairs with registered copies.
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i / 2);
      b1 = 1'(i % 2);
      check_comb($sformatf("w1_%0d", i));
      tick($sformatf("w1_%0d", i));
    end

    // Random stream with occasional reset.
    for (int i = 0; i < 150; i++) begin
      a2 = 2'($urandom); b2 = 2'($urandom);
      a8 = 8'($urandom); b8 = ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom);
      reset = ($urandom_range(0, 19) == 0);
      check_comb($sformatf("rnd%0d", i));
      tick($sformatf("rnd%0d", i));
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
